rans_decoder: RTL and testbench

//  Streaming rANS decoder: inverse of the rANS encoder datapath (same RESOLUTION/SYMBOL_WIDTH).

---
 rtl/rans_pkg.sv | 29 ++
 rtl/rans_dec_slot_table.sv | 44 ++++
 rtl/rans_decoder.sv | 154 +++++++++++++++
 tb/tb_rans_decoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// rtl/rans_pkg.sv - shared rANS constants, datapath types and decoder FSM encoding
package rans_pkg;

  localparam int RESOLUTION   = 10;
  localparam int SYMBOL_WIDTH = 8;
  localparam int STATE_WIDTH  = 32;
  localparam int IO_WIDTH     = 8;
  localparam int M            = 1 << RESOLUTION;
  localparam int NUM_SYMS     = 1 << SYMBOL_WIDTH;

  typedef logic [STATE_WIDTH-1:0]  state_t;
  typedef logic [SYMBOL_WIDTH-1:0] sym_t;
  typedef logic [RESOLUTION:0]     freq_t;
  typedef logic [RESOLUTION-1:0]   slot_t;

  // Renormalisation lower bound; the encoder starts from this state.
  localparam state_t L = state_t'(1) << (STATE_WIDTH - 9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOOKUP,
    S_UPDATE,
    S_EMIT,
    S_RENORM,
    S_FIN
  } dec_state_t;

endpackage

// File: rtl/rans_dec_slot_table.sv
// rtl/rans_dec_slot_table.sv - slot-to-symbol RAM with sequential range fill and tbl_busy
module rans_dec_slot_table
  import rans_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [SYMBOL_WIDTH-1:0] wr_sym,
  input  logic [RESOLUTION:0]     wr_freq,
  input  logic [RESOLUTION-1:0]   wr_cum,
  output logic                    tbl_busy,
  input  logic [RESOLUTION-1:0]   rd_addr,
  output logic [SYMBOL_WIDTH-1:0] rd_data
);

  sym_t  slot_ram [M];
  slot_t fill_addr;
  freq_t fill_left;
  sym_t  fill_sym;

  assign tbl_busy = (fill_left != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_addr <= '0;
      fill_left <= '0;
      fill_sym  <= '0;
    end else if (fill_left != '0) begin
      fill_addr <= fill_addr + slot_t'(1);
      fill_left <= fill_left - freq_t'(1);
    end else if (wr_en) begin
      fill_addr <= wr_cum;
      fill_left <= wr_freq;
      fill_sym  <= wr_sym;
    end
  end

  // RAM contents survive reset; the host reloads tables afterwards.
  always_ff @(posedge clk) begin
    if (fill_left != '0) slot_ram[fill_addr] <= fill_sym;
    rd_data <= slot_ram[rd_addr];
  end

endmodule

// File: rtl/rans_decoder.sv
// rtl/rans_decoder.sv - streaming rANS decoder: FSM, freq/cum table and state datapath
// Optional feature macro RANS_DEC_FINAL_CHECK_EN adds the err output (final state != L).
module rans_decoder
  import rans_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tbl_wr_en,
  input  logic [SYMBOL_WIDTH-1:0] tbl_wr_sym,
  input  logic [RESOLUTION:0]     tbl_wr_freq,
  input  logic [RESOLUTION-1:0]   tbl_wr_cum,
  output logic                    tbl_busy,
  input  logic                    start,
  input  logic [31:0]             sym_count,
  output logic                    busy,
  output logic                    done,
  input  logic [IO_WIDTH-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SYMBOL_WIDTH-1:0] sym_out,
  output logic                    sym_valid,
`ifdef RANS_DEC_FINAL_CHECK_EN
  output logic                    err,
`endif
  input  logic                    sym_ready
);

  dec_state_t  cur, nxt;
  state_t      state;
  logic [1:0]  byte_cnt;
  logic [1:0]  rn_cnt;
  logic [31:0] remaining;
  sym_t        sym_reg;
  sym_t        slot_sym;
  freq_t       freq_tbl [NUM_SYMS];
  slot_t       cum_tbl  [NUM_SYMS];
  freq_t       cur_freq;
  slot_t       cur_cum;
  state_t      upd;
  state_t      shifted;
  logic        tbl_accept;
  logic        start_ok;
  logic        need_byte;

  assign busy       = (cur != S_IDLE);
  assign sym_out    = sym_reg;
  assign tbl_accept = tbl_wr_en && !busy && !tbl_busy;
  assign start_ok   = start && !busy && !tbl_busy;
  assign need_byte  = (state < L) && (rn_cnt != 2'd2);
  assign shifted    = {state[STATE_WIDTH-IO_WIDTH-1:0], in_data};

  rans_dec_slot_table u_slot_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tbl_accept),
    .wr_sym   (tbl_wr_sym),
    .wr_freq  (tbl_wr_freq),
    .wr_cum   (tbl_wr_cum),
    .tbl_busy (tbl_busy),
    .rd_addr  (state[RESOLUTION-1:0]),
    .rd_data  (slot_sym)
  );

  always_ff @(posedge clk) begin
    if (tbl_accept) begin
      freq_tbl[tbl_wr_sym] <= tbl_wr_freq;
      cum_tbl[tbl_wr_sym]  <= tbl_wr_cum;
    end
  end

  // slot_sym is valid in UPDATE because state is unchanged since LOOKUP addressed the RAM.
  assign cur_freq = freq_tbl[slot_sym];
  assign cur_cum  = cum_tbl[slot_sym];
  assign upd      = state_t'(cur_freq) * (state >> RESOLUTION)
                  + state_t'(state[RESOLUTION-1:0]) - state_t'(cur_cum);

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    done      = 1'b0;
    case (cur)
      S_IDLE:   if (start_ok) nxt = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 2'd3) nxt = (remaining == '0) ? S_FIN : S_LOOKUP;
      end
      S_LOOKUP: nxt = S_UPDATE;
      S_UPDATE: nxt = S_EMIT;
      S_EMIT: begin
        sym_valid = 1'b1;
        if (sym_ready) nxt = S_RENORM;
      end
      S_RENORM: begin
        if (need_byte) in_ready = 1'b1;
        else           nxt = (remaining == '0) ? S_FIN : S_LOOKUP;
      end
      S_FIN: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= '0;
      byte_cnt  <= '0;
      rn_cnt    <= '0;
      remaining <= '0;
      sym_reg   <= '0;
    end else begin
      case (cur)
        S_IDLE: if (start_ok) begin
          remaining <= sym_count;
          byte_cnt  <= '0;
          state     <= '0;
        end
        S_LOAD: if (in_valid) begin
          state    <= shifted;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_UPDATE: begin
          state   <= upd;
          sym_reg <= slot_sym;
        end
        S_EMIT: if (sym_ready) begin
          remaining <= remaining - 32'd1;
          rn_cnt    <= '0;
        end
        S_RENORM: if (need_byte && in_valid) begin
          state  <= shifted;
          rn_cnt <= rn_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RANS_DEC_FINAL_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)            err <= 1'b0;
    else if (start_ok)     err <= 1'b0;
    else if (cur == S_FIN) err <= (state != L);
  end
`endif

endmodule

// File: tb/tb_rans_decoder.sv
// tb/tb_rans_decoder.sv - randomized scoreboard bench for rans_decoder
// Honours RANS_DEC_FINAL_CHECK_EN by also checking err.
`timescale 1ns/1ps
module tb_rans_decoder;

  localparam int          MT = 1024;
  localparam logic [31:0] LB = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [7:0]  tbl_wr_sym = '0;
  logic [10:0] tbl_wr_freq = '0;
  logic [9:0]  tbl_wr_cum = '0;
  logic        tbl_busy;
  logic        start = 1'b0;
  logic [31:0] sym_count = '0;
  logic        busy, done;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  sym_out;
  logic        sym_valid;
  logic        sym_ready = 1'b0;
`ifdef RANS_DEC_FINAL_CHECK_EN
  logic        err;
`endif

  rans_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_sym(tbl_wr_sym), .tbl_wr_freq(tbl_wr_freq),
    .tbl_wr_cum(tbl_wr_cum), .tbl_busy(tbl_busy),
    .start(start), .sym_count(sym_count), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .sym_valid(sym_valid),
`ifdef RANS_DEC_FINAL_CHECK_EN
    .err(err),
`endif
    .sym_ready(sym_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  int          m_freq [256];
  int          m_cum  [256];
  int          m_syms [$];
  int          m_used;
  logic [31:0] m_state;
  logic [7:0]  byte_q [$];
  int          exp_q  [$];
  int          consumed, done_cnt, ready_mode, hold_left;
  bit          valid_rand, gap_check, have_last;
  longint      last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode straight from the rANS rules over the queued byte stream.
  function automatic void model_decode(input int count);
    longint unsigned st;
    int idx, slot, s;
    st = 64'({byte_q[0], byte_q[1], byte_q[2], byte_q[3]});
    idx = 4;
    m_syms.delete();
    for (int i = 0; i < count; i++) begin
      slot = int'(st % 64'(MT));
      s = 0;
      for (int k = 0; k < 256; k++)
        if (m_freq[k] > 0 && slot >= m_cum[k] && slot < m_cum[k] + m_freq[k]) s = k;
      st = (64'(m_freq[s]) * (st / 64'(MT)) + 64'(slot) - 64'(m_cum[s])) & 64'hFFFF_FFFF;
      m_syms.push_back(s);
      for (int r = 0; r < 2 && st < 64'(LB); r++) begin
        st = ((st << 8) | 64'(byte_q[idx])) & 64'hFFFF_FFFF;
        idx++;
      end
    end
    m_used  = idx;
    m_state = st[31:0];
  endfunction

  always @(negedge clk) begin
    int e;
    if (start) have_last = 1'b0;
    if (sym_valid && sym_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sym_unexpected actual=%0h required=none", sym_out);
      end else begin
        e = exp_q.pop_front();
        chk("sym_out", 64'(sym_out), 64'(e));
      end
      if (gap_check && have_last) chk("sym_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc  = cyc;
      have_last = 1'b1;
    end
  end

  task automatic check_idle(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_sym_valid"}, 64'(sym_valid), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_tbl_busy"}, 64'(tbl_busy), 64'd0);
    chk({name, "_sym_out"}, 64'(sym_out), 64'd0);
`ifdef RANS_DEC_FINAL_CHECK_EN
    chk({name, "_err"}, 64'(err), 64'd0);
`endif
  endtask

  task automatic new_table();
    for (int k = 0; k < 256; k++) begin
      m_freq[k] = 0;
      m_cum[k]  = 0;
    end
  endtask

  task automatic tbl_write(input int s, input int f, input int c);
    int n = 0;
    tbl_wr_en = 1'b1;
    tbl_wr_sym = 8'(s);
    tbl_wr_freq = 11'(f);
    tbl_wr_cum = 10'(c);
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
    while (tbl_busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tbl_busy_cycles", 64'(n), 64'(f));
    m_freq[s] = f;
    m_cum[s]  = c;
  endtask

  // One clock: drive at posedge+1, sample at negedge, retire accepted byte after posedge.
  task automatic cycle();
    bit took;
    in_valid = (byte_q.size() > 0) && (!valid_rand || $urandom_range(0, 3) != 0);
    in_data  = in_valid ? byte_q[0] : 8'($urandom);
    case (ready_mode)
      1:       sym_ready = 1'b1;
      2:       sym_ready = (hold_left == 0);
      default: sym_ready = ($urandom_range(0, 2) != 0);
    endcase
    @(negedge clk);
    took = in_valid && in_ready;
    if (done) done_cnt++;
    if (ready_mode == 2 && hold_left > 0 && sym_valid) begin
      chk("hold_valid", 64'(sym_valid), 64'd1);
      chk("hold_sym", 64'(sym_out), 64'(exp_q[0]));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      hold_left--;
    end
    @(posedge clk); #1;
    if (took) begin
      void'(byte_q.pop_front());
      consumed++;
    end
  endtask

  task automatic run_frame(input string name, input int count, input int rmode, input bit vrand);
    int n = 0;
    model_decode(count);
    foreach (m_syms[i]) exp_q.push_back(m_syms[i]);
    ready_mode = rmode;
    valid_rand = vrand;
    hold_left  = 5;
    consumed   = 0;
    done_cnt   = 0;
    start      = 1'b1;
    sym_count  = count;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
`ifdef RANS_DEC_FINAL_CHECK_EN
    chk({name, "_err_cleared"}, 64'(err), 64'd0);
`endif
    while (done_cnt == 0 && n < 1500) begin
      cycle();
      n++;
    end
    chk({name, "_no_timeout"}, 64'(n < 1500), 64'd1);
    chk({name, "_busy_after_done"}, 64'(busy), 64'd0);
`ifdef RANS_DEC_FINAL_CHECK_EN
    chk({name, "_err"}, 64'(err), 64'(m_state != LB));
`endif
    cycle();
    cycle();
    chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, "_bytes_consumed"}, 64'(consumed), 64'(m_used));
    chk({name, "_syms_left"}, 64'(exp_q.size()), 64'd0);
    byte_q.delete();
    exp_q.delete();
    in_valid  = 1'b0;
    sym_ready = 1'b0;
  endtask

  task automatic load_t2();
    new_table();
    tbl_write(8'h41, 512, 0);
    tbl_write(8'h42, 512, 512);
  endtask

  task automatic rand_table();
    int k, rem, f, c, s;
    int used [$];
    bit dup;
    new_table();
    k = $urandom_range(1, 6);
    rem = MT;
    c = 0;
    for (int i = 0; i < k; i++) begin
      do begin
        s = $urandom_range(0, 255);
        dup = 1'b0;
        foreach (used[j]) if (used[j] == s) dup = 1'b1;
      end while (dup);
      used.push_back(s);
      f = (i == k - 1) ? rem : $urandom_range(1, rem - (k - 1 - i));
      tbl_write(s, f, c);
      c += f;
      rem -= f;
    end
  endtask

  initial begin
    int n, cnt;
    gap_check = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    new_table();
    tbl_write(0, 1024, 0);
    byte_q = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h5A, 8'h5A};
    gap_check = 1'b1;
    run_frame("t1", 3, 1, 0);
    gap_check = 1'b0;

    byte_q = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h77};
    run_frame("t4", 3, 2, 0);

    load_t2();
    tbl_write(8'h99, 0, 5);
    byte_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h33};
    run_frame("t2", 1, 0, 1);

    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_frame("zero_count", 0, 1, 1);

    byte_q = '{8'h01, 8'h00, 8'h02, 8'h01};
    run_frame("t6", 1, 1, 0);

    new_table();
    tbl_write(0, 1023, 0);
    tbl_write(7, 1, 1023);
    byte_q = '{8'h00, 8'h80, 8'h00, 8'h00, 8'hAB, 8'hCD};
    run_frame("t3", 1, 1, 1);

    byte_q = '{8'h00, 8'h80, 8'h00, 8'h00};
    exp_q.push_back(0);
    ready_mode = 1;
    valid_rand = 1'b0;
    consumed = 0;
    start = 1'b1;
    sym_count = 1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(in_ready && byte_q.size() == 0) && n < 200) begin
      cycle();
      n++;
    end
    chk("t5_reached_renorm", 64'(n < 200), 64'd1);
    chk("t5_bytes_before_reset", 64'(consumed), 64'd4);
    chk("t5_sym_taken", 64'(exp_q.size()), 64'd0);
    in_valid = 1'b0;
    sym_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("t5_reset");
    rst_n = 1'b1;
    exp_q.delete();
    load_t2();
    byte_q = '{8'h01, 8'h00, 8'h02, 8'h00};
    run_frame("t5_after", 1, 0, 1);

    for (int fr = 0; fr < 24; fr++) begin
      if (fr % 4 == 0) rand_table();
      cnt = $urandom_range(0, 6);
      repeat (4 + 2 * cnt + 2) byte_q.push_back(8'($urandom));
      run_frame("rnd", cnt, ($urandom_range(0, 1) == 0) ? 0 : 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
